// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: two requesters share the register file's single write port.
// A has fixed priority; B wins after STARVE_LIMIT consecutive denied cycles.
module reg_wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter bit DROP_ZERO    = 1,
    parameter int CNT_W        = 16
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             WB_stall,
    input  logic             A_valid,
    input  logic [4:0]       A_addr,
    input  logic [31:0]      A_data,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [4:0]       B_addr,
    input  logic [31:0]      B_data,
    output logic             B_ready,
    output logic             REG_write_1,
    output logic [4:0]       REG_address_wr,
    output logic [31:0]      REG_data_wb_in1,
    output logic [CNT_W-1:0] WB_conflict_cnt
);
    localparam logic [3:0]       LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]  starve_cnt;
    logic        grant_any;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    always_comb begin
        A_ready = 1'b0;
        B_ready = 1'b0;
        if (!WB_stall) begin
            if (B_valid && (starve_cnt == LIMIT || !A_valid))
                B_ready = 1'b1;
            else if (A_valid)
                A_ready = 1'b1;
        end
    end

    assign grant_any = A_ready | B_ready;
    assign sel_addr  = B_ready ? B_addr : A_addr;
    assign sel_data  = B_ready ? B_data : A_data;

    // Counts cycles B has been waiting, stall cycles included.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset)
            starve_cnt <= 4'd0;
        else if (B_ready || !B_valid)
            starve_cnt <= 4'd0;
        else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            REG_write_1     <= 1'b0;
            REG_address_wr  <= 5'd0;
            REG_data_wb_in1 <= 32'd0;
        end else if (grant_any) begin
            REG_write_1     <= !(DROP_ZERO && sel_addr == 5'd0);
            REG_address_wr  <= sel_addr;
            REG_data_wb_in1 <= sel_data;
        end else begin
            REG_write_1     <= 1'b0;
        end
    end

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset)
            WB_conflict_cnt <= '0;
        else if (A_valid && B_valid && WB_conflict_cnt != CNT_MAX)
            WB_conflict_cnt <= WB_conflict_cnt + 1'b1;
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed + randomized bench for reg_wb_arbiter against a cycle-level
// reference model of the grant rules and the write-port register.
module tb_reg_wb_arbiter;
    localparam int LIMIT = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0, rst = 1'b0, stall = 1'b0;
    logic          a_v = 1'b0, b_v = 1'b0;
    logic [4:0]    a_a = '0, b_a = '0;
    logic [31:0]   a_d = '0, b_d = '0;
    logic          a_r, b_r, we;
    logic [4:0]    wa;
    logic [31:0]   wd;
    logic [CW-1:0] ccnt;

    int n_cmp = 0, n_err = 0;

    // reference model state
    int          m_wait = 0, m_conf = 0;
    logic        m_we = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0;
    logic        g_a, g_b, obs_a, obs_b;

    reg_wb_arbiter #(.STARVE_LIMIT(LIMIT), .DROP_ZERO(1), .CNT_W(CW)) dut (
        .SYS_clk(clk), .SYS_reset(rst), .WB_stall(stall),
        .A_valid(a_v), .A_addr(a_a), .A_data(a_d), .A_ready(a_r),
        .B_valid(b_v), .B_addr(b_a), .B_data(b_d), .B_ready(b_r),
        .REG_write_1(we), .REG_address_wr(wa), .REG_data_wb_in1(wd),
        .WB_conflict_cnt(ccnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: drive, check at negedge, advance model at posedge.
    task automatic cycle(input logic st, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        stall = st; a_v = av; a_a = aa; a_d = ad; b_v = bv; b_a = ba; b_d = bd;
        g_b = !st && bv && (m_wait >= LIMIT || !av);
        g_a = !st && av && !g_b;
        @(negedge clk);
        obs_a = a_r; obs_b = b_r;
        check("a_ready", {31'd0, a_r}, {31'd0, g_a});
        check("b_ready", {31'd0, b_r}, {31'd0, g_b});
        check("reg_write", {31'd0, we}, {31'd0, m_we});
        check("reg_addr", {27'd0, wa}, {27'd0, m_addr});
        check("reg_data", wd, m_data);
        check("conflict_cnt", 32'(ccnt), 32'(m_conf));
        @(posedge clk);
        if (g_a || g_b) begin
            m_addr = g_b ? ba : aa;
            m_data = g_b ? bd : ad;
            m_we   = (m_addr != 0);
        end else m_we = 0;
        m_wait = (!bv || g_b) ? 0 : (m_wait + 1 > LIMIT ? LIMIT : m_wait + 1);
        if (av && bv) m_conf = (m_conf + 1 > CMAX) ? CMAX : m_conf + 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        stall = 0; a_v = 0; b_v = 0;
        #1 rst = 1;
        #1;
        check("rst_write", {31'd0, we}, 32'd0);
        check("rst_addr", {27'd0, wa}, 32'd0);
        check("rst_data", wd, 32'd0);
        check("rst_conflict", 32'(ccnt), 32'd0);
        #2 rst = 0;
        m_wait = 0; m_conf = 0; m_we = 0; m_addr = 0; m_data = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic        ra_v, rb_v, rst_n;
        logic [4:0]  ra_a, rb_a;
        logic [31:0] ra_d, rb_d;

        rst = 1;
        #12 rst = 0;
        @(posedge clk); #1;

        // idle after reset
        idle(10);
        check("idle_write", {31'd0, we}, 32'd0);

        // single A write
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        check("a_single_ready", {31'd0, obs_a}, 32'd1);
        check("a_single_we", {31'd0, we}, 32'd1);
        check("a_single_addr", {27'd0, wa}, 32'd5);
        check("a_single_data", wd, 32'hDEADBEEF);
        idle(1);
        check("a_single_we_drop", {31'd0, we}, 32'd0);

        // starvation: A wins LIMIT cycles, then B
        pulse_reset();
        for (int i = 0; i < LIMIT; i++) begin
            cycle(0, 1, 5'(i + 1), 32'h100 + i, 1, 7, 32'hB0B0);
            check("starve_a_win", {31'd0, obs_a}, 32'd1);
        end
        cycle(0, 1, 9, 32'h200, 1, 7, 32'hB0B0);
        check("starve_b_win", {31'd0, obs_b}, 32'd1);
        check("starve_b_addr", {27'd0, wa}, 32'd7);
        check("starve_conflict", 32'(ccnt), 32'd4);
        // wait counter must be back at 0: A wins again with B waiting
        cycle(0, 1, 9, 32'h200, 1, 8, 32'h1);
        check("starve_reset_a", {31'd0, obs_a}, 32'd1);
        idle(1);

        // address 0 write suppressed but handshake completes
        cycle(0, 0, 0, 0, 1, 0, 32'h1234);
        check("zero_b_ready", {31'd0, obs_b}, 32'd1);
        check("zero_we", {31'd0, we}, 32'd0);
        check("zero_data", wd, 32'h1234);
        idle(1);

        // stall blocks grants, then A goes the cycle stall drops
        cycle(1, 1, 3, 32'h33, 0, 0, 0);
        check("stall_a0", {31'd0, obs_a}, 32'd0);
        cycle(1, 1, 3, 32'h33, 0, 0, 0);
        check("stall_a1", {31'd0, obs_a}, 32'd0);
        cycle(0, 1, 3, 32'h33, 0, 0, 0);
        check("stall_release", {31'd0, obs_a}, 32'd1);
        idle(1);
        check("stall_write", {31'd0, we}, 32'd0);

        // async reset while a write is on the port, with B partly starved
        cycle(0, 1, 4, 32'h44, 1, 6, 32'h66);
        cycle(0, 1, 4, 32'h45, 1, 6, 32'h66);
        check("pre_reset_we", {31'd0, we}, 32'd1);
        pulse_reset();
        for (int i = 0; i < LIMIT; i++) begin
            cycle(0, 1, 2, 32'h22, 1, 6, 32'h66);
            check("post_reset_a", {31'd0, obs_a}, 32'd1);
        end
        cycle(0, 1, 2, 32'h22, 1, 6, 32'h66);
        check("post_reset_b", {31'd0, obs_b}, 32'd1);

        // randomized traffic with requesters holding until accepted
        ra_v = 0; rb_v = 0; ra_a = 0; rb_a = 0; ra_d = 0; rb_d = 0;
        for (int i = 0; i < 400; i++) begin
            if (!ra_v || g_a) begin
                ra_v = ($urandom_range(0, 9) < 7);
                ra_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                ra_d = $urandom;
            end
            if (!rb_v || g_b) begin
                rb_v = ($urandom_range(0, 9) < 6);
                rb_a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                rb_d = $urandom;
            end
            rst_n = ($urandom_range(0, 3) == 0);
            cycle(rst_n, ra_v, ra_a, ra_d, rb_v, rb_a, rb_d);
        end
        check("conflict_saturated", 32'(ccnt), 32'(CMAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Arbitrates two write-back requesters onto the single write port of the 32x32 register file. Requester A is the main ALU pipeline. Requester B is the load / multicycle unit. Uses fixed A-first priority with a starvation guard for B, a valid/ready handshake, optional $zero write suppression, and a registered write port that drives the register file's write-enable, address and data inputs directly.

Parameters:
STARVE_LIMIT, 3, number of consecutive denied cycles after which B wins over A (1..15)
DROP_ZERO, 1, when 1 an accepted write to address 0 completes the handshake but produces no register-file write
CNT_W, 16, width of the saturating conflict counter

Ports:
SYS_clk  in  1  system clock, all state on rising edge
SYS_reset  in  1  asynchronous, active-high reset
WB_stall  in  1  when high, no grants are issued this cycle
A_valid  in  1  requester A has a write pending
A_addr  in  5  requester A destination register
A_data  in  32  requester A write data
A_ready  out  1  A transfer accepted this cycle (combinational)
B_valid  in  1  requester B has a write pending
B_addr  in  5  requester B destination register
B_data  in  32  requester B write data
B_ready  out  1  B transfer accepted this cycle (combinational)
REG_write_1  out  1  register-file write enable (registered)
REG_address_wr  out  5  register-file write address (registered)
REG_data_wb_in1  out  32  register-file write data (registered)
WB_conflict_cnt  out  CNT_W  saturating count of cycles with A_valid & B_valid

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - REG_write_1=0, REG_address_wr=0, REG_data_wb_in1=0.
  - Starvation counter = 0; WB_conflict_cnt = 0.
  - Any transfer granted in that cycle is lost; requesters must retry.
- Handshake: a transfer occurs when X_valid & X_ready at a rising edge. Requesters hold valid/addr/data stable until ready. At most one of A_ready/B_ready is high per cycle.
- Grant logic (combinational, from valid, WB_stall and starve_cnt):
  - WB_stall=1: A_ready=B_ready=0.
  - else if B_valid & (starve_cnt==STARVE_LIMIT | !A_valid): B_ready=1.
  - else if A_valid: A_ready=1.
  - else: neither.
- starve_cnt (4 bits):
  - Cleared when B is granted or B_valid=0.
  - Otherwise +1 per cycle, including stall cycles, saturating at STARVE_LIMIT.
- Output register, latency 1. After a transfer at edge N, from edge N through edge N+1:
  - REG_write_1=1, REG_address_wr=granted addr, REG_data_wb_in1=granted data.
  - The register file commits the write at edge N+1.
  - Exception: if DROP_ZERO=1 and addr==0, REG_write_1=0. Address and data outputs still update.
- No transfer at an edge: REG_write_1=0. Address and data outputs hold their previous values.
- Back-to-back transfers: one per cycle sustained. REG_write_1 stays high continuously.
- Same address from A then B in consecutive cycles: writes are issued in grant order, so the later grant's data is final.
- WB_conflict_cnt: increments each cycle A_valid & B_valid, regardless of stall. Saturates at 2^CNT_W-1, with no wrap.

Test Plan:
- Reset then idle -> all outputs 0. A_ready=B_ready=0 with no valids. REG_write_1 stays 0 for 10 cycles.
- A_valid with addr 5, data 0xDEADBEEF for 1 cycle -> A_ready=1 that cycle. Next cycle REG_write_1=1, REG_address_wr=5, REG_data_wb_in1=0xDEADBEEF. Following cycle REG_write_1=0.
- A_valid held continuously (new data each cycle) and B_valid with addr 7, STARVE_LIMIT=3 -> A granted 3 cycles. B granted on the 4th cycle, then REG_address_wr=7 next cycle. starve_cnt back to 0. WB_conflict_cnt=4.
- DROP_ZERO=1: B writes addr 0, data 0x1234 -> B_ready=1. Next cycle REG_write_1=0, and the register file's $zero reads 0.
- WB_stall=1 for 2 cycles with A_valid -> A_ready=0 both cycles. On stall release, A is granted the same cycle and the write issues one cycle later.
- Assert SYS_reset asynchronously between edges while REG_write_1=1 -> REG_write_1 drops immediately. Counters read 0. After deassert, a pending A_valid is granted on the first cycle.
